// File: rtl/uart_mmio_ctrl.sv
// CPU-bus front end for serial_port: TX/RX byte FIFOs, DATA/STATUS/CTRL registers
// and a level interrupt. TX bytes are handed to serial_port one at a time.
module uart_mmio_ctrl #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  bus_addr,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq,
    input  logic        sp_int_req,
    output logic        sp_int_ack,
    input  logic [7:0]  sp_rx_data,
    output logic [7:0]  sp_tx_data,
    output logic        sp_write_enable,
    input  logic        sp_write_busy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = (DEPTH_LOG2)'(1);
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} tx_state_t;

    logic [7:0]            tx_mem [DEPTH];
    logic [7:0]            rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg, rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [DEPTH_LOG2:0]   tx_count_reg, tx_count_next, rx_count_reg, rx_count_next;
    tx_state_t             tx_state_reg;
    logic [1:0]            timer_reg;
    logic [1:0]            ctrl_reg, ctrl_next;
    logic                  rx_ovr_reg, rx_ovr_next, tx_ovf_reg, tx_ovf_next;
    logic                  irq_reg, irq_next, ack_reg, write_enable_reg;
    logic [7:0]            tx_data_reg;

    logic tx_empty, tx_full, tx_pop, tx_wr_req, tx_push, tx_drop;
    logic rx_empty, rx_full, rx_pop, rx_capture, rx_push, rx_drop;
    logic status_wr, fsm_idle_next, rx_avail, tx_space, tx_idle;
    logic [7:0] tx_head, rx_head;
    logic unused_bits;

    assign unused_bits = ^bus_wdata[31:8];

    assign tx_head  = tx_mem[tx_rd_ptr_reg];
    assign rx_head  = rx_mem[rx_rd_ptr_reg];
    assign tx_empty = (tx_count_reg == '0);
    assign tx_full  = (tx_count_reg == FULL_COUNT);
    assign rx_empty = (rx_count_reg == '0);
    assign rx_full  = (rx_count_reg == FULL_COUNT);

    // The FSM pop frees a slot in the same cycle, so a write to a full FIFO still lands.
    assign tx_pop    = (tx_state_reg == IDLE) && !tx_empty && !sp_write_busy;
    assign tx_wr_req = bus_write && (bus_addr == ADDR_DATA);
    assign tx_push   = tx_wr_req && (!tx_full || tx_pop);
    assign tx_drop   = tx_wr_req && !tx_push;

    assign rx_pop     = bus_read && (bus_addr == ADDR_DATA) && !rx_empty;
    assign rx_capture = sp_int_req && !ack_reg;
    assign rx_push    = rx_capture && (!rx_full || rx_pop);
    assign rx_drop    = rx_capture && !rx_push;

    assign status_wr   = bus_write && (bus_addr == ADDR_STATUS);
    assign rx_ovr_next = rx_drop || (rx_ovr_reg && !(status_wr && bus_wdata[3]));
    assign tx_ovf_next = tx_drop || (tx_ovf_reg && !(status_wr && bus_wdata[4]));
    assign ctrl_next   = (bus_write && bus_addr == ADDR_CTRL) ? bus_wdata[1:0] : ctrl_reg;

    assign rx_avail = !rx_empty;
    assign tx_space = !tx_full;
    assign tx_idle  = tx_empty && (tx_state_reg == IDLE);

    always_comb begin
        tx_count_next = tx_count_reg;
        if (tx_push && !tx_pop)
            tx_count_next = tx_count_reg + COUNT_ONE;
        else if (!tx_push && tx_pop)
            tx_count_next = tx_count_reg - COUNT_ONE;
    end

    always_comb begin
        rx_count_next = rx_count_reg;
        if (rx_push && !rx_pop)
            rx_count_next = rx_count_reg + COUNT_ONE;
        else if (!rx_push && rx_pop)
            rx_count_next = rx_count_reg - COUNT_ONE;
    end

    // irq tracks the state that will hold after this edge, so it has no extra lag.
    assign fsm_idle_next = ((tx_state_reg == IDLE) && !tx_pop)
                        || ((tx_state_reg == WAIT_HI) && !sp_write_busy && (timer_reg == 2'd3))
                        || ((tx_state_reg == WAIT_LO) && !sp_write_busy);
    assign irq_next = (ctrl_next[0] && (rx_count_next != '0))
                   || (ctrl_next[1] && (tx_count_next == '0) && fsm_idle_next);

    always_comb begin
        bus_rdata = 32'd0;
        case (bus_addr)
            ADDR_DATA:   bus_rdata = rx_empty ? 32'd0 : {24'd0, rx_head};
            ADDR_STATUS: bus_rdata = {27'd0, tx_ovf_reg, rx_ovr_reg, tx_idle, tx_space, rx_avail};
            ADDR_CTRL:   bus_rdata = {30'd0, ctrl_reg};
            default:     bus_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr_reg] <= bus_wdata[7:0];
        if (rx_push)
            rx_mem[rx_wr_ptr_reg] <= sp_rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr_reg    <= '0;
            tx_rd_ptr_reg    <= '0;
            rx_wr_ptr_reg    <= '0;
            rx_rd_ptr_reg    <= '0;
            tx_count_reg     <= '0;
            rx_count_reg     <= '0;
            tx_state_reg     <= IDLE;
            timer_reg        <= 2'd0;
            ctrl_reg         <= 2'd0;
            rx_ovr_reg       <= 1'b0;
            tx_ovf_reg       <= 1'b0;
            irq_reg          <= 1'b0;
            ack_reg          <= 1'b0;
            write_enable_reg <= 1'b0;
            tx_data_reg      <= 8'd0;
        end else begin
            if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PTR_ONE;
            if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + PTR_ONE;
            if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + PTR_ONE;
            if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + PTR_ONE;
            tx_count_reg <= tx_count_next;
            rx_count_reg <= rx_count_next;
            ctrl_reg     <= ctrl_next;
            rx_ovr_reg   <= rx_ovr_next;
            tx_ovf_reg   <= tx_ovf_next;
            irq_reg      <= irq_next;
            ack_reg      <= rx_capture;

            case (tx_state_reg)
                IDLE: begin
                    if (tx_pop) begin
                        tx_state_reg     <= ISSUE;
                        tx_data_reg      <= tx_head;
                        write_enable_reg <= 1'b1;
                    end
                end
                ISSUE: begin
                    write_enable_reg <= 1'b0;
                    timer_reg        <= 2'd0;
                    tx_state_reg     <= WAIT_HI;
                end
                WAIT_HI: begin
                    // Give up after four cycles if the transmitter never reports busy.
                    if (sp_write_busy)
                        tx_state_reg <= WAIT_LO;
                    else if (timer_reg == 2'd3)
                        tx_state_reg <= IDLE;
                    else
                        timer_reg <= timer_reg + 2'd1;
                end
                WAIT_LO: begin
                    if (!sp_write_busy)
                        tx_state_reg <= IDLE;
                end
                default: tx_state_reg <= IDLE;
            endcase
        end
    end

    assign irq             = irq_reg;
    assign sp_int_ack      = ack_reg;
    assign sp_tx_data      = tx_data_reg;
    assign sp_write_enable = write_enable_reg;
endmodule
